pc_sequencer: RTL

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer with prioritised redirects, stall hold/pending capture and halt.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] EXC_VEC  = 32'h0000_0180
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        exc_i,
  input  logic        jr_i,
  input  logic [31:0] jr_target_i,
  input  logic        jump_i,
  input  logic [31:0] jump_target_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  input  logic        halt_i,
  input  logic        resume_i,
  output logic [31:0] pc_o,
  output logic        fetch_valid_o,
  output logic        redir_o,
  output logic [1:0]  state_o,
  output logic        misalign_o
);
  localparam logic [1:0] RUN = 2'd0, HOLD = 2'd1, PEND = 2'd2, HALTED = 2'd3;
  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d, pend_q, pend_d;
  logic [2:0]  pri_q, pri_d;
  logic        redir_q, redir_d, mis_q, mis_d;
  logic [2:0]  req_pri;
  logic [31:0] raw_tgt, req_tgt, pc_inc;
  logic        req_bad;
  // Priority code doubles as the pending-overwrite comparison key: exc > jr > jump > branch.
  always_comb begin
    req_pri = exc_i ? 3'd4 : jr_i ? 3'd3 : jump_i ? 3'd2 : branch_i ? 3'd1 : 3'd0;
    raw_tgt = jr_i ? jr_target_i : jump_i ? jump_target_i : branch_target_i;
    req_bad = !exc_i && (jr_i || jump_i || branch_i) && (raw_tgt[1:0] != 2'b00);
    req_tgt = (exc_i || req_bad) ? EXC_VEC : raw_tgt;
    pc_inc  = pc_q + 32'd4;
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      pend_q  <= 32'd0;
      pri_q   <= 3'd0;
      redir_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      pri_q   <= pri_d;
      redir_q <= redir_d;
      mis_q   <= mis_d;
    end
  end
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    pri_d   = pri_q;
    redir_d = 1'b0;
    mis_d   = mis_q;
    case (state_q)
      RUN: begin
        if (!stall_i) begin
          pc_d    = (req_pri != 3'd0) ? req_tgt : pc_inc;
          redir_d = (req_pri != 3'd0);
          mis_d   = mis_q | req_bad;
          state_d = (halt_i && req_pri == 3'd0) ? HALTED : RUN;
        end else if (req_pri != 3'd0) begin
          state_d = PEND;
          pend_d  = req_tgt;
          pri_d   = req_pri;
          mis_d   = mis_q | req_bad;
        end else begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (!stall_i) begin
          state_d = RUN;
        end else if (req_pri != 3'd0) begin
          state_d = PEND;
          pend_d  = req_tgt;
          pri_d   = req_pri;
          mis_d   = mis_q | req_bad;
        end
      end
      PEND: begin
        if (!stall_i) begin
          pc_d    = exc_i ? EXC_VEC : pend_q;
          redir_d = 1'b1;
          state_d = RUN;
          pend_d  = 32'd0;
          pri_d   = 3'd0;
        end else if (req_pri > pri_q) begin
          pend_d = req_tgt;
          pri_d  = req_pri;
          mis_d  = mis_q | req_bad;
        end
      end
      HALTED: begin
        if (exc_i) begin
          pc_d    = EXC_VEC;
          redir_d = 1'b1;
          state_d = RUN;
        end else if (resume_i) begin
          state_d = RUN;
        end
      end
    endcase
  end
  always_comb begin
    fetch_valid_o = rst_i && (state_q == RUN) && !stall_i;
    pc_o          = pc_q;
    redir_o       = redir_q;
    state_o       = state_q;
    misalign_o    = mis_q;
  end
endmodule
